br_resolve_unit: RTL and testbench
==================================

// Module: br_resolve_unit
// PURPOSE
//  Resolution end of the fetch-prediction interface. Queues each prediction issued at fetch.
//  At decode it pops the oldest one against the actual branch/jump outcome, then drives the
//  PC redirect, the fetch flush (chng2nop) and the predictor table update port.
//  Sits between the decode-stage comparator/target adder and the fetch-side predictor.
// PARAMETERS
//  PC_W      32  program counter width
//  IDX_W     9   predictor table index width (pc[IDX_W-1:0])
//  DEPTH     4   in-flight prediction FIFO entries (power of 2, >=2)
//  FLUSH_CYC 1   cycles chng2nop is held after a redirect (>=1)
// PORTS
//  clk           in   1      clock, posedge
//  nrst          in   1      reset, asynchronous, active-low
//  pred_valid    in   1      fetch pushes a control-flow prediction
//  pred_pc       in   PC_W   PC of predicted instruction
//  pred_taken    in   1      predicted direction (counter MSB, or hit jump)
//  pred_hit      in   1      target table validity bit at fetch
//  pred_target   in   PC_W   predicted target
//  pred_ready    out  1      FIFO can accept a push
//  res_valid     in   1      decode has resolved the oldest control-flow instr
//  res_is_jmp    in   1      1 = unconditional jump, 0 = conditional branch
//  res_eq        in   1      1 = beq-type, 0 = bne-type
//  res_zero      in   1      comparator result (operands equal)
//  res_target    in   PC_W   computed target (PC+imm)
//  redirect_valid out 1      load redirect_pc into PC this cycle
//  redirect_pc   out  PC_W   corrected fetch address
//  chng2nop      out  1      squash wrong-path fetched instruction(s)
//  upd_valid     out  1      write predictor tables
//  upd_idx       out  IDX_W  table index
//  upd_taken     out  1      actual outcome for counter update
//  upd_alloc     out  1      write target+valid bit (taken and !hit, or target mismatch)
//  upd_target    out  PC_W   target to write
//  err_underflow out  1      sticky: res_valid seen with empty FIFO
// BEHAVIOUR
//  Reset: all outputs 0 except pred_ready=1; FIFO empty; FSM=RUN; pointers/count 0.
//  FIFO: push when pred_valid&&pred_ready; pred_ready = (count<DEPTH) && state==RUN.
//   Push+pop in the same cycle is legal at full (count unchanged); pointers wrap mod DEPTH.
//  Resolution, when res_valid && count>0 && state==RUN, using head entry h:
//   actual = res_is_jmp ? 1 : (res_eq ? res_zero : ~res_zero).
//   mis = (actual!=h.taken) | (actual & h.taken & (h.target!=res_target)).
//   Head is popped in the same cycle. All result outputs are registered (latency 1 cycle).
//  Outputs on cycle N+1 for a resolution at N:
//   upd_valid=1, upd_idx=h.pc[IDX_W-1:0], upd_taken=actual, upd_target=res_target,
//   upd_alloc=actual&(~h.hit | h.target!=res_target).
//   If mis: redirect_valid=1 (one cycle), redirect_pc = actual ? res_target : h.pc+4
//   (mod 2^PC_W), chng2nop=1; FSM -> FLUSH.
//  FSM RUN: normal. FLUSH: holds chng2nop=1 for FLUSH_CYC cycles, pred_ready=0,
//   res_valid ignored, then -> RUN. Entering FLUSH clears the FIFO (younger entries are
//   wrong-path); a push in the mispredict cycle is dropped.
//  res_valid with empty FIFO: no update/redirect; err_underflow set until reset.
//  pred_valid while !pred_ready: dropped, no state change.
//  Async reset mid-flush/mid-update: all outputs drop to reset values immediately.
// CONFIGURATION
//  BRU_PERF_EN defined: adds outputs perf_br_cnt[31:0] (resolutions counted) and
//   perf_mis_cnt[31:0] (mispredicts counted). Both saturate at 2^32-1 and reset to 0.
//  BRU_PERF_EN undefined: counters and ports absent; behaviour otherwise identical.
// TESTING
//  T1 reset: nrst=0 async mid-cycle -> all outputs 0, pred_ready=1, err_underflow=0.
//  T2 correct predict: push pc=0x100,taken=0; bne res_zero=1 -> N+1 upd_valid=1, upd_idx=0x100,
//   upd_taken=0, redirect_valid=0.
//  T3 taken mispredict: push pc=0x200,taken=0,hit=0; beq res_zero=1,target=0x240 -> redirect_pc=0x240,
//   chng2nop=1, upd_alloc=1.
//  T4 not-taken mispredict: push pc=0xFFFFFFFC,taken=1; beq res_zero=0 -> redirect_pc=0x0, FIFO cleared.
//  T5 full: 4 pushes -> pred_ready=0; 5th dropped; push+pop same cycle keeps count=4.
//  T6 empty resolve: res_valid on empty FIFO -> no upd_valid, err_underflow=1 sticky.

Source files
------------

// File: rtl/br_resolve_unit.sv
// Branch resolution unit: queues fetch-time predictions, resolves the oldest one at decode,
// and drives the PC redirect, fetch squash and predictor update. Optional counters: BRU_PERF_EN.
module br_resolve_unit #(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 9,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic             pred_hit,
  input  logic [PC_W-1:0]  pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_is_jmp,
  input  logic             res_eq,
  input  logic             res_zero,
  input  logic [PC_W-1:0]  res_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             chng2nop,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             upd_alloc,
  output logic [PC_W-1:0]  upd_target,
  output logic             err_underflow
`ifdef BRU_PERF_EN
  ,
  output logic [31:0]      perf_br_cnt,
  output logic [31:0]      perf_mis_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic [FC_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;

  logic [PC_W-1:0]   r_fifo_pc     [DEPTH];
  logic              r_fifo_taken  [DEPTH];
  logic              r_fifo_hit    [DEPTH];
  logic [PC_W-1:0]   r_fifo_target [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_redir_vld_p1, r_chng2nop_p1, r_upd_vld_p1;
  logic              r_upd_taken_p1, r_upd_alloc_p1, r_err_uflow;
  logic [PC_W-1:0]   r_redir_pc_p1, r_upd_target_p1;
  logic [IDX_W-1:0]  r_upd_idx_p1;

  logic [PC_W-1:0]   w_head_pc, w_head_target;
  logic              w_head_taken, w_head_hit;
  logic              w_run, w_actual, w_tgt_diff, w_mis;
  logic              w_pop, w_push, w_flush_go, w_uflow;

  // Stage p0: head lookup and resolution
  assign w_head_pc     = r_fifo_pc[r_rd_ptr];
  assign w_head_taken  = r_fifo_taken[r_rd_ptr];
  assign w_head_hit    = r_fifo_hit[r_rd_ptr];
  assign w_head_target = r_fifo_target[r_rd_ptr];

  assign w_run      = (r_state == ST_RUN);
  assign w_actual   = res_is_jmp | (res_eq ? res_zero : ~res_zero);
  assign w_tgt_diff = (w_head_target != res_target);
  assign w_mis      = (w_actual != w_head_taken) | (w_actual & w_head_taken & w_tgt_diff);
  assign w_pop      = res_valid && (r_count != '0) && w_run;
  assign w_flush_go = w_pop && w_mis;
  assign w_uflow    = res_valid && (r_count == '0) && w_run;

  assign pred_ready = (r_count < CNT_W'(DEPTH)) && w_run;
  // A correctly predicted pop frees a slot, so a push at full is still taken that cycle.
  assign w_push     = pred_valid && w_run && !w_flush_go && (pred_ready || w_pop);

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_flush_go) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) w_state_nxt = ST_RUN;
        else                   w_flush_cnt_nxt = r_flush_cnt - 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]     <= pred_pc;
      r_fifo_taken[r_wr_ptr]  <= pred_taken;
      r_fifo_hit[r_wr_ptr]    <= pred_hit;
      r_fifo_target[r_wr_ptr] <= pred_target;
    end
  end

  // Younger entries behind a mispredict are wrong-path, so the whole queue is dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush_go) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Stage p1: registered redirect and predictor update
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_redir_vld_p1  <= 1'b0;
      r_redir_pc_p1   <= '0;
      r_chng2nop_p1   <= 1'b0;
      r_upd_vld_p1    <= 1'b0;
      r_upd_idx_p1    <= '0;
      r_upd_taken_p1  <= 1'b0;
      r_upd_alloc_p1  <= 1'b0;
      r_upd_target_p1 <= '0;
      r_err_uflow     <= 1'b0;
    end else begin
      r_redir_vld_p1  <= w_flush_go;
      r_redir_pc_p1   <= !w_flush_go ? '0 :
                         (w_actual ? res_target : w_head_pc + PC_W'(4));
      r_chng2nop_p1   <= (w_state_nxt == ST_FLUSH);
      r_upd_vld_p1    <= w_pop;
      r_upd_idx_p1    <= w_pop ? w_head_pc[IDX_W-1:0] : '0;
      r_upd_taken_p1  <= w_pop & w_actual;
      r_upd_alloc_p1  <= w_pop & w_actual & (~w_head_hit | w_tgt_diff);
      r_upd_target_p1 <= w_pop ? res_target : '0;
      if (w_uflow) r_err_uflow <= 1'b1;
    end
  end

  assign redirect_valid = r_redir_vld_p1;
  assign redirect_pc    = r_redir_pc_p1;
  assign chng2nop       = r_chng2nop_p1;
  assign upd_valid      = r_upd_vld_p1;
  assign upd_idx        = r_upd_idx_p1;
  assign upd_taken      = r_upd_taken_p1;
  assign upd_alloc      = r_upd_alloc_p1;
  assign upd_target     = r_upd_target_p1;
  assign err_underflow  = r_err_uflow;

`ifdef BRU_PERF_EN
  logic [31:0] r_perf_br, r_perf_mis;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else begin
      if (w_pop && (r_perf_br != '1))       r_perf_br  <= r_perf_br + 1'b1;
      if (w_flush_go && (r_perf_mis != '1)) r_perf_mis <= r_perf_mis + 1'b1;
    end
  end

  assign perf_br_cnt  = r_perf_br;
  assign perf_mis_cnt = r_perf_mis;
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: directed scenarios then random traffic, each cycle compared
// against a queue-based model of the prediction FIFO and resolution rules.
module tb_br_resolve_unit;
  localparam int PC_W      = 32;
  localparam int IDX_W     = 9;
  localparam int DEPTH     = 4;
  localparam int FLUSH_CYC = 1;

  logic             clk = 1'b0;
  logic             nrst;
  logic             pred_valid, pred_taken, pred_hit, pred_ready;
  logic [PC_W-1:0]  pred_pc, pred_target;
  logic             res_valid, res_is_jmp, res_eq, res_zero;
  logic [PC_W-1:0]  res_target;
  logic             redirect_valid, chng2nop, upd_valid, upd_taken, upd_alloc, err_underflow;
  logic [PC_W-1:0]  redirect_pc, upd_target;
  logic [IDX_W-1:0] upd_idx;
`ifdef BRU_PERF_EN
  logic [31:0]      perf_br_cnt, perf_mis_cnt;
`endif

  br_resolve_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
`ifdef BRU_PERF_EN
    .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt),
`endif
    .clk(clk), .nrst(nrst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_hit(pred_hit), .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_is_jmp(res_is_jmp), .res_eq(res_eq),
    .res_zero(res_zero), .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .chng2nop(chng2nop),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_alloc(upd_alloc), .upd_target(upd_target), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic            hit;
    logic [PC_W-1:0] tgt;
  } ent_t;

  ent_t q[$];
  int   flush_rem;
  bit   uflow;
  int   checks = 0;
  int   errors = 0;

  logic             e_rv, e_c2n, e_uv, e_ut, e_ua;
  logic [PC_W-1:0]  e_rpc, e_utgt;
  logic [IDX_W-1:0] e_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("redirect_valid", redirect_valid, e_rv);
    chk("redirect_pc",    redirect_pc,    e_rpc);
    chk("chng2nop",       chng2nop,       e_c2n);
    chk("upd_valid",      upd_valid,      e_uv);
    chk("upd_idx",        upd_idx,        e_idx);
    chk("upd_taken",      upd_taken,      e_ut);
    chk("upd_alloc",      upd_alloc,      e_ua);
    chk("upd_target",     upd_target,     e_utgt);
    chk("err_underflow",  err_underflow,  uflow);
  endtask

  task automatic model_reset();
    q.delete();
    flush_rem = 0;
    uflow = 0;
    e_rv = 0; e_rpc = '0; e_c2n = 0; e_uv = 0; e_idx = '0; e_ut = 0; e_ua = 0; e_utgt = '0;
  endtask

  task automatic idle();
    pred_valid = 0; pred_pc = '0; pred_taken = 0; pred_hit = 0; pred_target = '0;
    res_valid = 0; res_is_jmp = 0; res_eq = 0; res_zero = 0; res_target = '0;
  endtask

  task automatic push_in(input logic [PC_W-1:0] pc, input logic tk, input logic ht,
                         input logic [PC_W-1:0] tg);
    pred_valid = 1; pred_pc = pc; pred_taken = tk; pred_hit = ht; pred_target = tg;
  endtask

  task automatic res_in(input logic jmp, input logic eq, input logic zero,
                        input logic [PC_W-1:0] tg);
    res_valid = 1; res_is_jmp = jmp; res_eq = eq; res_zero = zero; res_target = tg;
  endtask

  // One clock: predict from current inputs and model, advance, compare after the edge.
  task automatic cycle();
    ent_t h;
    bit   run, pop, mis, act, push;
    h   = '0;
    run = (flush_rem == 0);
    chk("pred_ready", pred_ready, (q.size() < DEPTH) && run);
    act = res_is_jmp ? 1'b1 : (res_eq ? res_zero : !res_zero);
    pop = res_valid && run && (q.size() > 0);
    mis = 0;
    if (pop) begin
      h   = q[0];
      mis = (act != h.taken) || (act && h.taken && (h.tgt != res_target));
    end
    push = pred_valid && run && !(pop && mis) && ((q.size() < DEPTH) || pop);
    e_uv   = pop;
    e_idx  = pop ? h.pc[IDX_W-1:0] : '0;
    e_ut   = pop && act;
    e_ua   = pop && act && (!h.hit || (h.tgt != res_target));
    e_utgt = pop ? res_target : '0;
    e_rv   = pop && mis;
    e_rpc  = (pop && mis) ? (act ? res_target : h.pc + 32'd4) : '0;
    if (res_valid && run && q.size() == 0) uflow = 1;
    if (!run) flush_rem--;
    if (pop) void'(q.pop_front());
    if (pop && mis) begin
      q.delete();
      flush_rem = FLUSH_CYC;
    end
    if (push) q.push_back('{pc: pred_pc, taken: pred_taken, hit: pred_hit, tgt: pred_target});
    e_c2n = (flush_rem > 0);
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    idle();
    nrst = 0;
    model_reset();
    @(negedge clk);
    chk("rst_pred_ready", pred_ready, 1'b1);
    check_outs();
    nrst = 1;

    // Correct not-taken bne
    push_in(32'h100, 0, 0, 32'h0); cycle();
    idle(); res_in(0, 0, 1, 32'h104); cycle();
    chk("T2_upd_idx", upd_idx, 9'h100);
    chk("T2_redirect", redirect_valid, 1'b0);

    // Taken mispredict on beq, no target hit
    idle(); push_in(32'h200, 0, 0, 32'h0); cycle();
    idle(); res_in(0, 1, 1, 32'h240); cycle();
    chk("T3_redirect_pc", redirect_pc, 32'h240);
    chk("T3_chng2nop", chng2nop, 1'b1);
    chk("T3_alloc", upd_alloc, 1'b1);
    idle(); push_in(32'h280, 0, 0, 32'h0); cycle();
    idle(); cycle();

    // Not-taken mispredict at top of address space; younger entry and same-cycle push dropped
    push_in(32'hFFFF_FFFC, 1, 1, 32'h1234); cycle();
    push_in(32'h300, 0, 0, 32'h0); cycle();
    push_in(32'h400, 0, 0, 32'h0); res_in(0, 1, 0, 32'h1234); cycle();
    chk("T4_redirect_pc", redirect_pc, 32'h0);
    idle(); cycle();
    idle(); cycle();

    // Resolve with an empty queue
    res_in(0, 1, 1, 32'h50); cycle();
    chk("T6_no_upd", upd_valid, 1'b0);
    chk("T6_uflow", err_underflow, 1'b1);
    idle(); cycle(); cycle();
    chk("T6_uflow_sticky", err_underflow, 1'b1);

    // Fill, overflow attempt, push+pop at full, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      idle(); push_in(32'h500 + 32'(8 * i), 0, 0, 32'h0); cycle();
    end
    chk("T5_full", pred_ready, 1'b0);
    push_in(32'h5F0, 0, 0, 32'h0); cycle();
    push_in(32'h6A0, 0, 0, 32'h0); res_in(0, 0, 1, 32'h0); cycle();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); res_in(0, 0, 1, 32'h0); cycle();
    end
    chk("T5_last_idx", upd_idx, 9'h0A0);
    idle(); cycle();

    // Asynchronous reset in the middle of a redirect/flush
    push_in(32'h700, 0, 1, 32'h0); cycle();
    idle(); res_in(1, 0, 0, 32'h800); cycle();
    chk("T1_pre_c2n", chng2nop, 1'b1);
    #2;
    nrst = 0;
    #1;
    model_reset();
    chk("T1_pred_ready", pred_ready, 1'b1);
    check_outs();
    idle();
    @(posedge clk);
    @(negedge clk);
    nrst = 1;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        push_in($urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom),
                32'($urandom_range(0, 3) * 64));
      if ($urandom_range(0, 9) < 4)
        res_in(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               32'($urandom_range(0, 3) * 64));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
